// File: rtl/lsu_rmw.sv
// lsu_rmw -- load/store unit between the execute stage and a word-only data memory.
//
// Byte/halfword/word loads are served by a single word read and lane extraction.
// Word stores write directly; byte/halfword stores use a read-modify-write over
// two memory cycles. Misaligned, out-of-range and illegal-funct3 requests
// are answered with an error code and never touch memory.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid_i       core request valid
//   req_ready_o       unit idle and able to accept a request
//   req_we_i          1 = store, 0 = load
//   req_funct3_i      RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_addr_i        byte address
//   req_wdata_i       store data, LSB-aligned
//   rsp_valid_o       response valid
//   rsp_ready_i       core accepts the response
//   rsp_rdata_o       extended load result (0 for stores and errors)
//   rsp_err_o         00 ok, 01 misaligned, 10 access fault, 11 illegal funct3
//   mem_addr_o        word-aligned memory address
//   mem_we_o          memory write enable
//   mem_wd_o          memory write data
//   mem_rd_i          memory combinational read data
module lsu_rmw #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic [1:0]            rsp_err_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_wd_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_i
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_RMW_RD  = 3'd2;
    localparam logic [2:0] S_RMW_WR  = 3'd3;
    localparam logic [2:0] S_STORE_W = 3'd4;
    localparam logic [2:0] S_RESP    = 3'd5;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_MISALGN = 2'b01;
    localparam logic [1:0] ERR_FAULT   = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL = 2'b11;

    // One extra bit so MEM_WORDS*4 is representable even when it equals 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(64'(MEM_WORDS) * 64'd4);

    // Error classification with priority illegal > misaligned > fault.
    function automatic logic [1:0] classify(
        input logic                  we,
        input logic [2:0]            f3,
        input logic [ADDR_WIDTH-1:0] addr
    );
        logic illegal;
        logic misaligned;
        logic fault;
        if (we) begin
            illegal = (f3 > 3'b010);
        end else begin
            illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
        misaligned = ((f3[1:0] == 2'b01) && addr[0]) ||
                     ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        fault      = ({1'b0, addr} >= MEM_BYTES);
        if (illegal)         return ERR_ILLEGAL;
        else if (misaligned) return ERR_MISALGN;
        else if (fault)      return ERR_FAULT;
        else                 return ERR_OK;
    endfunction

    // Pick the addressed lane and extend it to a full word.
    function automatic logic [DATA_WIDTH-1:0] load_extract(
        input logic [2:0]            f3,
        input logic [1:0]            off,
        input logic [DATA_WIDTH-1:0] word
    );
        logic signed [7:0]            b;
        logic signed [15:0]           h;
        logic signed [DATA_WIDTH-1:0] r;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  r = DATA_WIDTH'(b);
            3'b001:  r = DATA_WIDTH'(h);
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed byte (SB) or halfword (SH) inside the old word.
    function automatic logic [DATA_WIDTH-1:0] store_merge(
        input logic [2:0]            f3,
        input logic [1:0]            off,
        input logic [DATA_WIDTH-1:0] word,
        input logic [DATA_WIDTH-1:0] wd
    );
        logic [DATA_WIDTH-1:0] m;
        m = word;
        if (f3[1:0] == 2'b00) begin
            m[{off, 3'b000} +: 8] = wd[7:0];
        end else begin
            m[{off[1], 4'b0000} +: 16] = wd[15:0];
        end
        return m;
    endfunction

    logic [2:0]            state_q;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [1:0]            err_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] merge_q;
    logic [1:0]            req_err;

    assign req_err = classify(req_we_i, req_funct3_i, req_addr_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= ERR_OK;
            rdata_q <= '0;
            merge_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        we_q    <= req_we_i;
                        f3_q    <= req_funct3_i;
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        err_q   <= req_err;
                        // Stores and errors respond with zero data.
                        rdata_q <= '0;
                        if (req_err != ERR_OK) begin
                            state_q <= S_RESP;
                        end else if (!req_we_i) begin
                            state_q <= S_LOAD;
                        end else if (req_funct3_i[1:0] == 2'b10) begin
                            state_q <= S_STORE_W;
                        end else begin
                            state_q <= S_RMW_RD;
                        end
                    end
                end
                S_LOAD: begin
                    rdata_q <= load_extract(f3_q, addr_q[1:0], mem_rd_i);
                    state_q <= S_RESP;
                end
                S_RMW_RD: begin
                    merge_q <= mem_rd_i;
                    state_q <= S_RMW_WR;
                end
                S_RMW_WR: begin
                    state_q <= S_RESP;
                end
                S_STORE_W: begin
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        // rst_n gates ready so every output reads 0 while reset is held.
        req_ready_o = rst_n && (state_q == S_IDLE);
        rsp_valid_o = (state_q == S_RESP);
        rsp_rdata_o = (state_q == S_RESP) ? rdata_q : '0;
        rsp_err_o   = (state_q == S_RESP) ? err_q : ERR_OK;
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_wd_o    = '0;
        case (state_q)
            S_LOAD, S_RMW_RD: begin
                mem_addr_o = {addr_q[ADDR_WIDTH-1:2], 2'b00};
            end
            S_RMW_WR: begin
                mem_addr_o = {addr_q[ADDR_WIDTH-1:2], 2'b00};
                mem_we_o   = 1'b1;
                mem_wd_o   = store_merge(f3_q, addr_q[1:0], merge_q, wdata_q);
            end
            S_STORE_W: begin
                mem_addr_o = {addr_q[ADDR_WIDTH-1:2], 2'b00};
                mem_we_o   = 1'b1;
                mem_wd_o   = wdata_q;
            end
            default: begin
            end
        endcase
    end

    // we_q is informational only; the state already encodes load vs store.
    logic unused_we;
    assign unused_we = we_q;

endmodule

// File: tb/tb_lsu_rmw.sv
module tb_lsu_rmw;

    logic        clk;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic [1:0]  rsp_err_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;

    lsu_rmw #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(1024)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_funct3_i (req_funct3_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .mem_addr_o   (mem_addr_o),
        .mem_we_o     (mem_we_o),
        .mem_wd_o     (mem_wd_o),
        .mem_rd_i     (mem_rd_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory attached to the unit: combinational read, posedge write.
    logic [31:0] mem_arr [1024];
    logic [9:0]  widx;
    assign widx     = 10'(mem_addr_o >> 2);
    assign mem_rd_i = mem_arr[widx];
    always @(posedge clk) if (mem_we_o) mem_arr[widx] <= mem_wd_o;

    // Reference memory image, maintained by the model only.
    logic [31:0] ref_mem [1024];

    int n_tests;
    int n_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: error code from the access rules.
    function automatic logic [1:0] model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        int size;
        size = int'(f3) % 4;  // 0 byte, 1 half, 2 word
        if (we ? (f3 > 2) : (f3 == 3 || f3 == 6 || f3 == 7)) return 2'b11;
        if ((size == 1 && a % 2 != 0) || (size == 2 && a % 4 != 0)) return 2'b01;
        if (a >= 32'd4096) return 2'b10;
        return 2'b00;
    endfunction

    // Reference: load result from the word image using shifts and integer sign handling.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        int v;
        case (f3)
            3'd0: begin v = int'((w >> (8 * (a % 4))) & 32'hFF);   if (v > 127)   v -= 256;   end
            3'd4: begin v = int'((w >> (8 * (a % 4))) & 32'hFF); end
            3'd1: begin v = int'((w >> (8 * (a % 4))) & 32'hFFFF); if (v > 32767) v -= 65536; end
            3'd5: begin v = int'((w >> (8 * (a % 4))) & 32'hFFFF); end
            default: v = int'(w);
        endcase
        return 32'(v);
    endfunction

    // Reference: word after a store of the given size.
    function automatic logic [31:0] model_store(input logic [2:0] f3, input logic [31:0] a,
                                                input logic [31:0] w, input logic [31:0] d);
        logic [31:0] mask;
        int sh;
        sh = 8 * int'(a % 4);
        if (f3 == 3'd2) return d;
        mask = (f3 == 3'd0 ? 32'hFF : 32'hFFFF) << sh;
        return (w & ~mask) | ((d << sh) & mask);
    endfunction

    task automatic drive_idle_junk;
        req_valid_i  = 1'b0;
        req_we_i     = 1'($urandom);
        req_funct3_i = 3'($urandom);
        req_addr_i   = $urandom;
        req_wdata_i  = $urandom;
    endtask

    // Issue one request, check latency, memory activity, response and hold behaviour.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input int hold);
        logic [1:0]  e_err;
        logic [31:0] e_rdata;
        logic [31:0] e_wd;
        int          e_lat;
        int          e_we;
        int          lat;
        int          we_cnt;
        int          w;
        logic [31:0] wd_seen;
        e_err   = model_err(we, f3, a);
        e_rdata = 32'd0;
        e_wd    = 32'd0;
        e_we    = 0;
        if (e_err != 2'b00)   e_lat = 1;
        else if (!we)         e_lat = 2;
        else if (f3 == 3'd2)  e_lat = 2;
        else                  e_lat = 3;
        if (e_err == 2'b00) begin
            if (!we) e_rdata = model_load(f3, a, ref_mem[a[11:2]]);
            else begin
                e_we = 1;
                e_wd = model_store(f3, a, ref_mem[a[11:2]], d);
            end
        end

        w = 0;
        while (!req_ready_o && w < 20) begin
            @(posedge clk); #1; w++;
        end
        if (!req_ready_o) begin
            chk("ready_timeout", {31'd0, req_ready_o}, 32'd1);
            return;
        end
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_funct3_i = f3;
        req_addr_i   = a;
        req_wdata_i  = d;
        @(posedge clk); #1;
        drive_idle_junk();

        lat = 1; we_cnt = 0; wd_seen = 32'd0;
        while (!rsp_valid_o && lat < 10) begin
            if (mem_we_o) begin
                we_cnt++;
                wd_seen = mem_wd_o;
            end
            @(posedge clk); #1; lat++;
        end
        chk("latency", 32'(lat), 32'(e_lat));
        chk("rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
        chk("rdata", rsp_rdata_o, e_rdata);
        chk("err", {30'd0, rsp_err_o}, {30'd0, e_err});
        chk("we_pulses", 32'(we_cnt), 32'(e_we));
        if (e_we == 1) chk("mem_wd", wd_seen, e_wd);

        rsp_ready_i = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, rsp_valid_o}, 32'd1);
            chk("hold_rdata", rsp_rdata_o, e_rdata);
            chk("hold_err", {30'd0, rsp_err_o}, {30'd0, e_err});
            chk("hold_ready", {31'd0, req_ready_o}, 32'd0);
            chk("hold_we", {31'd0, mem_we_o}, 32'd0);
        end
        rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        rsp_ready_i = 1'b0;
        chk("idle_ready", {31'd0, req_ready_o}, 32'd1);
        chk("idle_valid", {31'd0, rsp_valid_o}, 32'd0);

        if (e_we == 1) begin
            ref_mem[a[11:2]] = e_wd;
            chk("mem_word", mem_arr[a[11:2]], e_wd);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_req_ready"}, {31'd0, req_ready_o}, 32'd0);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid_o}, 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata_o, 32'd0);
        chk({tag, "_rsp_err"}, {30'd0, rsp_err_o}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr_o, 32'd0);
        chk({tag, "_mem_we"}, {31'd0, mem_we_o}, 32'd0);
        chk({tag, "_mem_wd"}, mem_wd_o, 32'd0);
    endtask

    initial begin
        logic [31:0] saved;
        n_tests = 0;
        n_fail  = 0;
        rst_n       = 1'b0;
        rsp_ready_i = 1'b0;
        drive_idle_junk();
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        #1;
        chk("post_reset_ready", {31'd0, req_ready_o}, 32'd1);

        // Fill the low words through full-word stores.
        for (int i = 0; i < 16; i++) do_req(1'b1, 3'd2, 32'(i * 4), $urandom, 0);

        // Directed loads on a known word.
        do_req(1'b1, 3'd2, 32'h4, 32'h8899AABB, 0);
        do_req(1'b0, 3'd0, 32'h5, 32'h0, 0);
        chk("lb_const", ref_mem[1], 32'h8899AABB);
        do_req(1'b0, 3'd5, 32'h6, 32'h0, 0);
        do_req(1'b0, 3'd1, 32'h6, 32'h0, 0);
        do_req(1'b0, 3'd2, 32'h4, 32'h0, 0);

        // Directed sub-word stores.
        do_req(1'b1, 3'd2, 32'h8, 32'h11223344, 0);
        do_req(1'b1, 3'd0, 32'h9, 32'h000000DE, 0);
        chk("sb_word", mem_arr[2], 32'h1122DE44);
        do_req(1'b1, 3'd1, 32'hA, 32'h0000BEEF, 0);
        chk("sh_word", mem_arr[2], 32'hBEEFDE44);

        // Error cases.
        do_req(1'b0, 3'd2, 32'h6, 32'h0, 0);
        do_req(1'b1, 3'd2, 32'h00001000, 32'hCAFEF00D, 0);
        do_req(1'b0, 3'd3, 32'h4, 32'h0, 0);
        do_req(1'b1, 3'd5, 32'h8, 32'h0, 0);

        // Long response stall.
        do_req(1'b0, 3'd2, 32'h4, 32'h0, 5);

        // Reset during the write cycle of a read-modify-write.
        saved = mem_arr[2];
        req_valid_i  = 1'b1;
        req_we_i     = 1'b1;
        req_funct3_i = 3'd0;
        req_addr_i   = 32'h9;
        req_wdata_i  = 32'h00000077;
        @(posedge clk); #1;
        drive_idle_junk();
        @(posedge clk); #1;
        chk("rmw_wr_we", {31'd0, mem_we_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("mid_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("reset_mem_kept", mem_arr[2], saved);
        chk("reset_mem_model", mem_arr[2], ref_mem[2]);
        chk("rel_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rel_valid", {31'd0, rsp_valid_o}, 32'd0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            if ($urandom_range(0, 7) == 0) a = 32'h1000 + $urandom_range(0, 255);
            else a = 32'($urandom_range(0, 63));
            do_req(1'($urandom), 3'($urandom), a, $urandom, $urandom_range(0, 2));
        end

        for (int i = 0; i < 16; i++) chk("final_mem", mem_arr[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
